// File: rtl/cmos_frame_packer.sv
// cmos_frame_packer
//   Frames an RGB565 pixel stream (de-qualified, pclk domain) using sensor
//   vsync, packs four pixels per 64-bit word for the frame-buffer write FIFO
//   and flags line/frame geometry errors and FIFO overflow.
//
// Ports
//   pclk           pixel clock, all logic on rising edge
//   rst            synchronous active-high reset
//   capture_en_i   capture enable, sampled on vsync rising edge only
//   vsync_i        sensor vsync, active-high blanking pulse
//   de_i           pixel valid
//   pdata_i[15:0]  pixel data
//   fifo_full_i    write FIFO full
//   wr_en_o        FIFO write strobe (one cycle per word)
//   wr_data_o      packed word, first pixel in [63:48]; holds between writes
//   frame_start_o  pulse: frame capture begins
//   frame_done_o   pulse: V_ACTIVE lines completed
//   line_err_o     pulse: line length != H_ACTIVE
//   frame_err_o    pulse: line count != V_ACTIVE at frame end
//   overflow_o     sticky until next frame_start_o: word dropped on full FIFO
module cmos_frame_packer #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        capture_en_i,
  input  logic        vsync_i,
  input  logic        de_i,
  input  logic [15:0] pdata_i,
  input  logic        fifo_full_i,
  output logic        wr_en_o,
  output logic [63:0] wr_data_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic        line_err_o,
  output logic        frame_err_o,
  output logic        overflow_o
);

  localparam logic [11:0] H_MAX  = 12'(H_ACTIVE);
  localparam logic [11:0] V_MAX  = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic        vsync_d0;
  logic        de_d;
  logic [11:0] x_cnt;
  logic [11:0] line_cnt;
  logic [1:0]  pix_idx;
  logic [63:0] pack_buf;

  logic vs_rise, vs_fall;
  logic start_evt, end_evt, pix_acc, line_end, pack_ok, word_done;

  always_comb begin
    vs_rise = vsync_i & ~vsync_d0;
    vs_fall = ~vsync_i & vsync_d0;
  end

  // State register
  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_rise && capture_en_i) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise) state_nxt = capture_en_i ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Event decode; vsync high masks all pixel activity so end_evt never
  // coincides with pixel acceptance or a line end.
  always_comb begin
    start_evt = (state == WAIT_VS) && vs_fall;
    end_evt   = (state == ACTIVE) && vs_rise;
    pix_acc   = (state == ACTIVE) && de_i && !vsync_i;
    line_end  = (state == ACTIVE) && !vsync_i && de_d && !de_i;
    pack_ok   = pix_acc && (line_cnt < V_MAX) && (x_cnt < H_MAX);
    word_done = pack_ok && (pix_idx == 2'd3);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_d0      <= 1'b0;
      de_d          <= 1'b0;
      x_cnt         <= '0;
      line_cnt      <= '0;
      pix_idx       <= '0;
      pack_buf      <= '0;
      wr_en_o       <= 1'b0;
      wr_data_o     <= '0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      line_err_o    <= 1'b0;
      frame_err_o   <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      vsync_d0      <= vsync_i;
      // de history only tracks accepted pixels, so line ends are only
      // recognised for lines that were actually seen in ACTIVE.
      de_d          <= pix_acc;
      wr_en_o       <= 1'b0;
      frame_start_o <= start_evt;
      frame_done_o  <= 1'b0;
      line_err_o    <= 1'b0;
      frame_err_o   <= end_evt && (line_cnt != V_MAX);

      if (start_evt) overflow_o <= 1'b0;

      if (start_evt || end_evt) begin
        x_cnt    <= '0;
        line_cnt <= '0;
        pix_idx  <= '0;
        pack_buf <= '0;
      end else if (line_end) begin
        line_err_o <= (x_cnt != H_MAX);
        if (line_cnt < V_MAX) begin
          line_cnt     <= line_cnt + 12'd1;
          frame_done_o <= (line_cnt == V_LAST);
        end
        x_cnt   <= '0;
        pix_idx <= '0;
      end else if (pix_acc) begin
        if (x_cnt != '1) x_cnt <= x_cnt + 12'd1;
        if (word_done) begin
          if (fifo_full_i) begin
            overflow_o <= 1'b1;
          end else begin
            wr_en_o   <= 1'b1;
            wr_data_o <= {pack_buf[63:16], pdata_i};
          end
          pix_idx <= '0;
        end else if (pack_ok) begin
          case (pix_idx)
            2'd0:    pack_buf[63:48] <= pdata_i;
            2'd1:    pack_buf[47:32] <= pdata_i;
            default: pack_buf[31:16] <= pdata_i;
          endcase
          pix_idx <= pix_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_frame_packer.sv
module tb_cmos_frame_packer;

  localparam int H = 8;
  localparam int V = 2;

  logic        pclk;
  logic        rst;
  logic        capture_en_i;
  logic        vsync_i;
  logic        de_i;
  logic [15:0] pdata_i;
  logic        fifo_full_i;
  logic        wr_en_o;
  logic [63:0] wr_data_o;
  logic        frame_start_o;
  logic        frame_done_o;
  logic        line_err_o;
  logic        frame_err_o;
  logic        overflow_o;

  cmos_frame_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .pclk(pclk), .rst(rst), .capture_en_i(capture_en_i), .vsync_i(vsync_i),
    .de_i(de_i), .pdata_i(pdata_i), .fifo_full_i(fifo_full_i),
    .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .frame_start_o(frame_start_o),
    .frame_done_o(frame_done_o), .line_err_o(line_err_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: expected words, and expected pulse vectors
  // {frame_start, frame_done, line_err, frame_err} in order of occurrence.
  logic [63:0] exp_words[$];
  logic [3:0]  exp_evts[$];

  // Reference model state
  bit capturing = 0;
  int line_idx  = 0;
  bit ovf_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge pclk) begin
    logic [3:0] evt;
    if (!rst) begin
      if (wr_en_o) begin
        if (exp_words.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected write: got %h expected none", wr_data_o);
        end else begin
          check("wr_data", wr_data_o, exp_words.pop_front());
        end
      end
      evt = {frame_start_o, frame_done_o, line_err_o, frame_err_o};
      if (evt != 4'b0) begin
        if (exp_evts.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected pulse {start,done,lerr,ferr}: got %b expected none", evt);
        end else begin
          check("pulses", {60'b0, evt}, {60'b0, exp_evts.pop_front()});
        end
      end
    end
  end

  task automatic drive(input logic de, input logic [15:0] d, input logic full, input logic vs);
    de_i = de; pdata_i = d; fifo_full_i = full; vsync_i = vs;
    @(posedge pclk); #1;
  endtask

  task automatic vsync_pulse(input bit en);
    check("overflow before vsync", {63'b0, overflow_o}, {63'b0, ovf_model});
    capture_en_i = en;
    if (capturing && line_idx != V) exp_evts.push_back(4'b0001);
    capturing = en;
    line_idx  = 0;
    if (en) begin
      exp_evts.push_back(4'b1000);
      ovf_model = 0;
    end
    repeat (3) drive(1'b0, 16'h0, 1'($urandom), 1'b1);
    repeat (3) drive(1'b0, 16'h0, 1'($urandom), 1'b0);
    check("overflow after start", {63'b0, overflow_o}, {63'b0, ovf_model});
  endtask

  // seq=1: pixels 1..len; otherwise random. drop[w]: FIFO full on word w completion.
  task automatic send_line(input int len, input bit seq, input logic [7:0] drop);
    logic [15:0] px[];
    bit counted;
    int nw;
    bit lerr, done;
    logic full;
    px = new[len];
    for (int k = 0; k < len; k++) px[k] = seq ? 16'(k + 1) : 16'($urandom);
    counted = capturing && (line_idx < V);
    if (counted) begin
      nw = ((len < H) ? len : H) / 4;
      for (int w = 0; w < nw; w++) begin
        if (drop[w]) ovf_model = 1;
        else exp_words.push_back({px[4*w], px[4*w+1], px[4*w+2], px[4*w+3]});
      end
    end
    if (capturing) begin
      lerr = (len != H);
      done = counted && (line_idx == V - 1);
      if (lerr || done) exp_evts.push_back({1'b0, done, lerr, 1'b0});
      if (counted) line_idx++;
    end
    for (int k = 0; k < len; k++) begin
      full = ((k % 4 == 3) && (k < H)) ? drop[k/4] : 1'($urandom);
      drive(1'b1, px[k], full, 1'b0);
    end
    repeat (2 + $urandom_range(0, 2)) drive(1'b0, 16'h0, 1'($urandom), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; capture_en_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0;
    pdata_i = '0; fifo_full_i = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset wr_en", {63'b0, wr_en_o}, 64'd0);
    check("reset wr_data", wr_data_o, 64'd0);
    check("reset pulses", {59'b0, frame_start_o, frame_done_o, line_err_o, frame_err_o, overflow_o}, 64'd0);
    rst = 1'b0;
    repeat (2) drive(1'b0, 16'h0, 1'b0, 1'b0);

    // 1: clean frame
    vsync_pulse(1);
    send_line(8, 1, 8'h00);
    send_line(8, 1, 8'h00);
    // 2: FIFO full on 2nd word of line 1
    vsync_pulse(1);
    send_line(8, 1, 8'h02);
    send_line(8, 1, 8'h00);
    // 3: short then long line
    vsync_pulse(1);
    send_line(6, 1, 8'h00);
    send_line(10, 1, 8'h00);
    // 4: single line frame
    vsync_pulse(1);
    send_line(8, 1, 8'h00);
    // 5: capture disabled, enable raised mid-frame
    vsync_pulse(0);
    send_line(8, 1, 8'h00);
    capture_en_i = 1'b1;
    send_line(8, 1, 8'h00);
    vsync_pulse(1);
    send_line(8, 1, 8'h00);
    send_line(8, 1, 8'h00);
    // 6: reset after 2nd pixel of a line
    vsync_pulse(1);
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 16'hCCCC, 1'b0, 1'b0);
    check("rst wr_en", {63'b0, wr_en_o}, 64'd0);
    check("rst wr_data", wr_data_o, 64'd0);
    check("rst pulses", {59'b0, frame_start_o, frame_done_o, line_err_o, frame_err_o, overflow_o}, 64'd0);
    check("rst words pending", 64'(exp_words.size()), 64'd0);
    check("rst pulses pending", 64'(exp_evts.size()), 64'd0);
    rst = 1'b0;
    capturing = 0; line_idx = 0; ovf_model = 0;
    drive(1'b1, 16'hDDDD, 1'b0, 1'b0);
    send_line(8, 1, 8'h00);
    vsync_pulse(1);
    send_line(8, 1, 8'h00);
    send_line(8, 1, 8'h00);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int nl;
      vsync_pulse(($urandom % 5) != 0);
      nl = $urandom_range(1, V + 1);
      for (int l = 0; l < nl; l++) begin
        int len;
        logic [7:0] drop;
        len  = ($urandom % 3 == 0) ? $urandom_range(1, H + 4) : H;
        drop = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
        send_line(len, 0, drop);
      end
    end
    vsync_pulse(1);
    repeat (5) drive(1'b0, 16'h0, 1'b0, 1'b0);

    check("words left in scoreboard", 64'(exp_words.size()), 64'd0);
    check("pulses left in scoreboard", 64'(exp_evts.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
